// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between one stream_rr_arbiter and the crossbar around it.
// The arbiter uses the slave modport; the crossbar (or a bench) drives through master.
interface stream_rr_arbiter_if #(
    parameter int S_DATA_COUNT = 2
);
    localparam int ID_WIDTH = $clog2(S_DATA_COUNT);

    logic [S_DATA_COUNT-1:0] req_i;
    logic [S_DATA_COUNT-1:0] s_valid_i;
    logic [S_DATA_COUNT-1:0] s_last_i;
    logic                    m_ready_i;
    logic [S_DATA_COUNT-1:0] grant_o;
    logic [ID_WIDTH-1:0]     grant_id_o;
    logic                    busy_o;

    modport slave (
        input  req_i,
        input  s_valid_i,
        input  s_last_i,
        input  m_ready_i,
        output grant_o,
        output grant_id_o,
        output busy_o
    );

    modport master (
        output req_i,
        output s_valid_i,
        output s_last_i,
        output m_ready_i,
        input  grant_o,
        input  grant_id_o,
        input  busy_o
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Per-slave round-robin arbiter with packet locking: a grant is held until the
// granted input's tlast beat, then handed directly to the next requester.
module stream_rr_arbiter #(
    parameter int S_DATA_COUNT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    stream_rr_arbiter_if.slave  bus
);
    localparam int ID_WIDTH = $clog2(S_DATA_COUNT);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [S_DATA_COUNT-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0]     grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;

    logic [ID_WIDTH-1:0]     next_ptr;
    logic                    release_pkt;
    logic [S_DATA_COUNT-1:0] arb_req;
    logic [ID_WIDTH-1:0]     arb_start;
    logic [ID_WIDTH-1:0]     arb_win;
    logic                    arb_found;
    logic [S_DATA_COUNT-1:0] arb_onehot;

    assign next_ptr = (grant_id_q == ID_WIDTH'(S_DATA_COUNT - 1)) ? '0
                                                                  : grant_id_q + ID_WIDTH'(1);

    assign release_pkt = (state_q == LOCKED) & bus.s_valid_i[grant_id_q]
                       & bus.m_ready_i & bus.s_last_i[grant_id_q];

    // While locked grant_q is the one-hot of the current owner, so masking with it
    // excludes the releasing input from the same-cycle re-arbitration.
    assign arb_req   = (state_q == LOCKED) ? (bus.req_i & ~grant_q) : bus.req_i;
    assign arb_start = (state_q == LOCKED) ? next_ptr : rr_ptr_q;

    always_comb begin
        int idx;
        logic [ID_WIDTH-1:0] cand;
        arb_found = 1'b0;
        arb_win   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            idx = int'(arb_start) + k;
            if (idx >= S_DATA_COUNT) begin
                idx = idx - S_DATA_COUNT;
            end
            cand = ID_WIDTH'(idx);
            if (!arb_found && arb_req[cand]) begin
                arb_found = 1'b1;
                arb_win   = cand;
            end
        end
    end

    always_comb begin
        arb_onehot = '0;
        for (int k = 0; k < S_DATA_COUNT; k++) begin
            arb_onehot[k] = (ID_WIDTH'(k) == arb_win);
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d    = LOCKED;
                    grant_d    = arb_onehot;
                    grant_id_d = arb_win;
                end
            end
            LOCKED: begin
                if (release_pkt) begin
                    rr_ptr_d = next_ptr;
                    if (arb_found) begin
                        grant_d    = arb_onehot;
                        grant_id_d = arb_win;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.grant_o    = grant_q;
    assign bus.grant_id_o = grant_id_q;
    assign bus.busy_o     = (state_q == LOCKED);
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter with three inputs: directed vector table, a
// mid-packet reset sequence, then random traffic against a rotation-distance model.
module tb_stream_rr_arbiter;
    localparam int S = 3;

    typedef struct {
        logic       rstN;
        logic [2:0] req;
        logic [2:0] valid;
        logic [2:0] last;
        logic       ready;
        logic [2:0] expGrant;
        logic [1:0] expId;
        logic       expBusy;
    } vec_t;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;
    vec_t vecs[$];

    bit   mBusy;
    int   mId;
    int   mPtr;

    stream_rr_arbiter_if #(.S_DATA_COUNT(S)) bus ();

    stream_rr_arbiter #(.S_DATA_COUNT(S)) dut (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic addVec(input logic r, input logic [2:0] req, input logic [2:0] valid,
                          input logic [2:0] last, input logic ready, input logic [2:0] g,
                          input logic [1:0] id, input logic busy);
        vec_t v;
        v.rstN = r; v.req = req; v.valid = valid; v.last = last; v.ready = ready;
        v.expGrant = g; v.expId = id; v.expBusy = busy;
        vecs.push_back(v);
    endtask

    // Inputs change just after a rising edge; outputs are sampled 1 time unit after the next one.
    task automatic applyStimulus(input logic r, input logic [2:0] req, input logic [2:0] valid,
                                 input logic [2:0] last, input logic ready);
        rstN          = r;
        bus.req_i     = req;
        bus.s_valid_i = valid;
        bus.s_last_i  = last;
        bus.m_ready_i = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] g,
                               input logic [1:0] id, input logic busy);
        checks++;
        if (bus.grant_o !== g) begin
            errors++;
            $display("[TB] FAIL %s grant_o got %b expected %b", name, bus.grant_o, g);
        end
        checks++;
        if (bus.grant_id_o !== id) begin
            errors++;
            $display("[TB] FAIL %s grant_id_o got %0d expected %0d", name, bus.grant_id_o, id);
        end
        checks++;
        if (bus.busy_o !== busy) begin
            errors++;
            $display("[TB] FAIL %s busy_o got %b expected %b", name, bus.busy_o, busy);
        end
    endtask

    // Winner is the requester closest to the pointer going upward with wrap.
    function automatic int pickWinner(input logic [2:0] r, input int ptr);
        int best;
        int bestDist;
        best = -1;
        bestDist = S;
        for (int k = 0; k < S; k++) begin
            if (r[k] && ((k - ptr + S) % S) < bestDist) begin
                bestDist = (k - ptr + S) % S;
                best = k;
            end
        end
        return best;
    endfunction

    task automatic modelStep(input logic r, input logic [2:0] req, input logic [2:0] valid,
                             input logic [2:0] last, input logic ready);
        int w;
        if (!r) begin
            mBusy = 1'b0; mId = 0; mPtr = 0;
        end else if (!mBusy) begin
            w = pickWinner(req, mPtr);
            if (w >= 0) begin
                mBusy = 1'b1; mId = w;
            end
        end else if (valid[mId] && ready && last[mId]) begin
            mPtr = (mId + 1) % S;
            w = pickWinner(req & ~(3'b001 << mId), mPtr);
            if (w >= 0) mId = w;
            else mBusy = 1'b0;
        end
    endtask

    initial begin
        logic       r, rdy;
        logic [2:0] rq, vl, ls, expG;
        checks = 0;
        errors = 0;
        rstN = 1'b0;
        bus.req_i = '0; bus.s_valid_i = '0; bus.s_last_i = '0; bus.m_ready_i = 1'b0;

        // reset, then first grant one cycle after release
        addVec(0, 3'b111, 3'b000, 3'b000, 0, 3'b000, 2'd0, 0);
        addVec(1, 3'b111, 3'b000, 3'b000, 0, 3'b001, 2'd0, 1);
        // four-beat packet on input 0, req[0] dropped after beat 2, no-bubble handoff to 1
        addVec(1, 3'b111, 3'b001, 3'b000, 1, 3'b001, 2'd0, 1);
        addVec(1, 3'b111, 3'b001, 3'b000, 1, 3'b001, 2'd0, 1);
        addVec(1, 3'b110, 3'b001, 3'b000, 1, 3'b001, 2'd0, 1);
        addVec(1, 3'b110, 3'b001, 3'b001, 1, 3'b010, 2'd1, 1);
        // single-beat packets, everyone requesting
        addVec(1, 3'b111, 3'b111, 3'b111, 1, 3'b100, 2'd2, 1);
        addVec(1, 3'b111, 3'b111, 3'b111, 1, 3'b001, 2'd0, 1);
        addVec(1, 3'b111, 3'b111, 3'b111, 1, 3'b010, 2'd1, 1);
        addVec(1, 3'b111, 3'b111, 3'b111, 1, 3'b100, 2'd2, 1);
        addVec(1, 3'b111, 3'b111, 3'b111, 1, 3'b001, 2'd0, 1);
        addVec(1, 3'b111, 3'b111, 3'b111, 1, 3'b010, 2'd1, 1);
        // backpressure on input 1 for five cycles, then release
        for (int i = 0; i < 5; i++) addVec(1, 3'b111, 3'b010, 3'b010, 0, 3'b010, 2'd1, 1);
        addVec(1, 3'b111, 3'b010, 3'b010, 1, 3'b100, 2'd2, 1);
        // sole requester: idle for a cycle with id held, then re-granted
        addVec(1, 3'b100, 3'b100, 3'b100, 1, 3'b000, 2'd2, 0);
        addVec(1, 3'b100, 3'b000, 3'b000, 1, 3'b100, 2'd2, 1);
        addVec(1, 3'b100, 3'b100, 3'b000, 1, 3'b100, 2'd2, 1);
        addVec(1, 3'b000, 3'b100, 3'b100, 1, 3'b000, 2'd2, 0);
        addVec(1, 3'b000, 3'b000, 3'b000, 1, 3'b000, 2'd2, 0);
        addVec(1, 3'b010, 3'b000, 3'b000, 1, 3'b010, 2'd1, 1);
        addVec(1, 3'b011, 3'b010, 3'b000, 1, 3'b010, 2'd1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].req, vecs[i].valid, vecs[i].last, vecs[i].ready);
            checkOutput($sformatf("vec%0d", i), vecs[i].expGrant, vecs[i].expId, vecs[i].expBusy);
        end

        // reset pulsed while locked on input 1: outputs clear before any clock edge
        rstN = 1'b0;
        #1;
        checkOutput("asyncReset", 3'b000, 2'd0, 1'b0);
        applyStimulus(0, 3'b011, 3'b010, 3'b010, 1);
        checkOutput("resetHeld", 3'b000, 2'd0, 1'b0);
        applyStimulus(1, 3'b011, 3'b000, 3'b000, 1);
        checkOutput("afterReset", 3'b001, 2'd0, 1'b1);

        $display("[TB] starting random traffic");
        applyStimulus(0, 3'b000, 3'b000, 3'b000, 0);
        modelStep(0, 3'b000, 3'b000, 3'b000, 0);
        for (int i = 0; i < 1500; i++) begin
            r   = ($urandom_range(0, 99) != 0);
            rq  = 3'($urandom_range(0, 7));
            vl  = 3'($urandom_range(0, 7));
            ls  = 3'($urandom_range(0, 7));
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(r, rq, vl, ls, rdy);
            modelStep(r, rq, vl, ls, rdy);
            expG = mBusy ? (3'b001 << mId) : 3'b000;
            checkOutput($sformatf("rand%0d", i), expG, 2'(mBusy ? mId : mId), mBusy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
